// File: rtl/pitch_shift_pkg.sv
// Shared constants and types for the pitch-shift bin buffer, reader and FFT stages.
package pitch_shift_pkg;

    localparam int unsigned NUM_BINS = 2048;
    localparam int unsigned IDX_W    = $clog2(NUM_BINS);
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } reader_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  index;
        logic              last;
    } bin_beat_t;

endpackage

// File: rtl/pitch_shift_reader_sync_fifo.sv
// Synchronous FIFO with count output and synchronous flush; pushes while full and pops while empty are dropped.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pitch_shift_reader.sv
// Read-side sequencer: sweeps the bin buffer once per frame and streams bins in order
// through a credit-limited FIFO so downstream backpressure never drops or repeats a bin.
module pitch_shift_reader
    import pitch_shift_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  output_index,
    input  logic [DATA_W-1:0] ps_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_index,
    output logic              m_last
);

    localparam int unsigned      FIFO_DEPTH = RD_LAT + 2;
    localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned      BEAT_W     = $bits(bin_beat_t);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BINS - 1);

    reader_state_t    state;
    reader_state_t    state_next;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] issue_idx_next;
    logic             done_next;
    logic             issue;

    logic [RD_LAT-1:0] pipe_valid;
    logic [IDX_W-1:0]  pipe_idx [RD_LAT];
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    bin_beat_t         push_beat;
    bin_beat_t         head;
    logic [BEAT_W-1:0] head_bits;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_valid[i]);
        end
    end

    // Every issued read owns a FIFO slot until popped, so a push can never find the FIFO full.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign pop         = m_valid && m_ready;

    always_comb begin
        state_next     = state;
        issue_idx_next = issue_idx;
        done_next      = 1'b0;
        issue          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = READ;
                    issue_idx_next = '0;
                end
            end
            READ: begin
                if (credit_used < (CNT_W + 1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (issue_idx == LAST_IDX) state_next = DRAIN;
                    else                       issue_idx_next = issue_idx + 1'b1;
                end
            end
            DRAIN: begin
                // Bins leave in order, so popping the last one means nothing remains queued or in flight.
                if (pop && head.last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_idx <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            issue_idx <= issue_idx_next;
            done      <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_idx[0] <= issue_idx;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_idx[i] <= pipe_idx[i-1];
        end
    end

    assign push            = pipe_valid[RD_LAT-1];
    assign push_beat.data  = ps_data;
    assign push_beat.index = pipe_idx[RD_LAT-1];
    assign push_beat.last  = (pipe_idx[RD_LAT-1] == LAST_IDX);

    sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .flush     (rst),
        .push      (push),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (head_bits),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign head         = bin_beat_t'(head_bits);
    assign output_index = issue_idx;
    assign busy         = (state != IDLE);
    assign m_valid      = !fifo_empty;
    assign m_data       = m_valid ? head.data  : '0;
    assign m_index      = m_valid ? head.index : '0;
    assign m_last       = m_valid && head.last;

endmodule

// File: tb/tb_pitch_shift_reader.sv
// Directed bench for pitch_shift_reader: buffer model returns {index, ~index} after RD_LAT cycles.
module tb_pitch_shift_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bin_word(input logic [10:0] i);
        return {10'b0, i, ~i};
    endfunction

    logic        rst;
    logic        start;
    logic        start_sw;
    logic        m_ready;
    int          rdy_mode = 0;

    logic        busy, done, m_valid, m_last;
    logic [10:0] output_index, m_index;
    logic [31:0] ps_data, m_data;

    logic        busy2, done2, mv2, ml2;
    logic [10:0] idx2, mi2;
    logic [31:0] ps2, md2, p2;

    logic        busy4, done4, mv4, ml4;
    logic [10:0] idx4, mi4;
    logic [31:0] ps4, md4;
    logic [31:0] p4 [3];

    pitch_shift_reader #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .output_index(output_index), .ps_data(ps_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    pitch_shift_reader #(.RD_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst), .start(start_sw), .busy(busy2), .done(done2),
        .output_index(idx2), .ps_data(ps2),
        .m_valid(mv2), .m_ready(1'b1), .m_data(md2), .m_index(mi2), .m_last(ml2)
    );

    pitch_shift_reader #(.RD_LAT(4)) dut_lat4 (
        .clk(clk), .rst(rst), .start(start_sw), .busy(busy4), .done(done4),
        .output_index(idx4), .ps_data(ps4),
        .m_valid(mv4), .m_ready(1'b1), .m_data(md4), .m_index(mi4), .m_last(ml4)
    );

    always @(posedge clk) ps_data <= bin_word(output_index);
    always @(posedge clk) begin
        p2  <= bin_word(idx2);
        ps2 <= p2;
    end
    always @(posedge clk) begin
        p4[0] <= bin_word(idx4);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        ps4   <= p4[2];
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int beats, order_errs, stab_errs, overlap_errs, done_cnt, last_flags;
    int first_valid = -1, last_cyc = -1, done_cyc = -1;
    int clr_seq = 0, clr_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [10:0] prev_idx;
    logic        prev_last;

    always @(negedge clk) begin
        if (clr_seq != clr_seen) begin
            clr_seen    = clr_seq;
            beats       = 0;
            order_errs  = 0;
            stab_errs   = 0;
            last_flags  = 0;
            first_valid = -1;
            last_cyc    = -1;
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data ||
                               m_index !== prev_idx || m_last !== prev_last))
                stab_errs++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (m_index !== 11'(beats) || m_data !== bin_word(11'(beats)) ||
                    m_last !== (beats == 2047))
                    order_errs++;
                if (m_last) begin
                    last_cyc = cyc;
                    last_flags++;
                end
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done && busy) overlap_errs++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            prev_last  = m_last;
        end
    end

    int sw2_first = -1, sw2_last = -1, sw2_beats = 0, sw2_err = 0, sw2_done = 0;
    int sw4_first = -1, sw4_last = -1, sw4_beats = 0, sw4_err = 0, sw4_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mv2 && sw2_first < 0) sw2_first = cyc;
            if (mv2) begin
                if (mi2 !== 11'(sw2_beats) || md2 !== bin_word(11'(sw2_beats)) || ml2 !== (sw2_beats == 2047))
                    sw2_err++;
                if (ml2) sw2_last = cyc;
                sw2_beats++;
            end
            if (done2) sw2_done++;
            if (done2 && busy2) sw2_err++;
            if (mv4 && sw4_first < 0) sw4_first = cyc;
            if (mv4) begin
                if (mi4 !== 11'(sw4_beats) || md4 !== bin_word(11'(sw4_beats)) || ml4 !== (sw4_beats == 2047))
                    sw4_err++;
                if (ml4) sw4_last = cyc;
                sw4_beats++;
            end
            if (done4) sw4_done++;
            if (done4 && busy4) sw4_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        tick();
        start = 1'b1;
        t     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("done_wait", done_cnt >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},    busy,         0);
        check_eq({tag, "_done"},    done,         0);
        check_eq({tag, "_m_valid"}, m_valid,      0);
        check_eq({tag, "_m_data"},  m_data,       0);
        check_eq({tag, "_m_index"}, m_index,      0);
        check_eq({tag, "_m_last"},  m_last,       0);
        check_eq({tag, "_out_idx"}, output_index, 0);
    endtask

    initial begin
        int t, t2, dc, n;
        rst      = 1'b1;
        start    = 1'b0;
        start_sw = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Latency sweep on the RD_LAT=2 and RD_LAT=4 instances
        tick();
        start_sw = 1'b1;
        t        = cyc;
        tick();
        start_sw = 1'b0;
        n = 0;
        while (sw4_done == 0 && n < 3000) begin
            tick();
            n++;
        end
        check_eq("lat2_first_valid", sw2_first - t, 4);
        check_eq("lat4_first_valid", sw4_first - t, 6);
        check_eq("lat2_beats",       sw2_beats, 2048);
        check_eq("lat4_beats",       sw4_beats, 2048);
        check_eq("lat2_errs",        sw2_err, 0);
        check_eq("lat4_errs",        sw4_err, 0);
        check_eq("lat2_last_cyc",    sw2_last - t, 2051);
        check_eq("lat4_last_cyc",    sw4_last - t, 2053);
        check_eq("lat2_done_cnt",    sw2_done, 1);
        check_eq("lat4_done_cnt",    sw4_done, 1);

        // Free run, m_ready held high
        clr_seq++;
        pulse_start(t);
        wait_done(1, 3000);
        check_eq("free_first_valid", first_valid - t, 3);
        check_eq("free_beats",       beats, 2048);
        check_eq("free_order",       order_errs, 0);
        check_eq("free_last_flags",  last_flags, 1);
        check_eq("free_last_cyc",    last_cyc - t, 2050);
        check_eq("free_done_cyc",    done_cyc - t, 2051);

        // Random backpressure
        rdy_mode = 1;
        clr_seq++;
        pulse_start(t);
        wait_done(2, 12000);
        rdy_mode = 0;
        check_eq("rand_beats",      beats, 2048);
        check_eq("rand_order",      order_errs, 0);
        check_eq("rand_stable",     stab_errs, 0);
        check_eq("rand_last_flags", last_flags, 1);

        // Start mid-frame ignored, start coincident with done honoured
        tick();
        clr_seq++;
        pulse_start(t);
        while (cyc < t + 500) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t + 2051) tick();
        start = 1'b1;
        t2    = cyc;
        tick();
        start = 1'b0;
        check_eq("restart_f1_beats", beats, 2048);
        check_eq("restart_f1_order", order_errs, 0);
        check_eq("restart_f1_done",  done_cyc - t, 2051);
        check_eq("restart_done_cnt", done_cnt, 3);
        clr_seq++;
        wait_done(4, 3000);
        check_eq("restart_f2_first", first_valid - t2, 3);
        check_eq("restart_f2_beats", beats, 2048);
        check_eq("restart_f2_order", order_errs, 0);
        check_eq("restart_f2_done",  done_cyc - t2, 2051);

        // Reset at beat 1000
        tick();
        clr_seq++;
        pulse_start(t);
        n = 0;
        while (beats < 1000 && n < 3000) begin
            tick();
            n++;
        end
        check_eq("rst_beat1000", beats >= 1000, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        dc = done_cnt;
        repeat (20) tick();
        check_eq("midrst_no_done", done_cnt - dc, 0);
        clr_seq++;
        pulse_start(t);
        wait_done(dc + 1, 3000);
        check_eq("postrst_beats", beats, 2048);
        check_eq("postrst_order", order_errs, 0);
        check_eq("postrst_done",  done_cyc - t, 2051);

        // Long stall right after start
        rdy_mode = 2;
        tick();
        clr_seq++;
        pulse_start(t);
        while (cyc < t + 50) tick();
        check_eq("stall_beats",   beats, 0);
        check_eq("stall_m_valid", m_valid, 1);
        check_eq("stall_m_index", m_index, 0);
        check_eq("stall_out_idx", output_index, 3);
        rdy_mode = 0;
        wait_done(dc + 2, 3000);
        check_eq("stall_final_beats", beats, 2048);
        check_eq("stall_order",       order_errs, 0);
        check_eq("stall_stable",      stab_errs, 0);
        check_eq("done_busy_overlap", overlap_errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pitch_shift_reader.md
# pitch_shift_reader

Read-side sequencer for the pitch-shift bin buffer. On a `start` pulse it sweeps `output_index` from 0 to NUM_BINS-1, captures the returned bin words after a fixed read latency, and presents them on a ready/valid stream to the inverse-FFT stage. A credit-limited output FIFO absorbs downstream backpressure, so no bin is ever dropped or duplicated.

## Interface
- NUM_BINS, 2048: bins per frame.
- IDX_W, 11: bin index width; equals log2(NUM_BINS).
- DATA_W, 32: bin word width; {real[31:16], imag[15:0]}, passed through untouched.
- RD_LAT, 1: cycles from `output_index` presented to `ps_data` valid; must be ≥1.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- busy  out  1  high in READ and DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- output_index  out  IDX_W  bin address driven to the bin buffer read port.
- ps_data  in  DATA_W  bin buffer read data.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  bin word.
- m_index  out  IDX_W  bin number of `m_data`.
- m_last  out  1  high with bin NUM_BINS-1.

## Operation
- FSM states:
  - IDLE: `start` → READ, issue counter = 0.
  - READ: on each issue cycle, increment the counter; the issue of index NUM_BINS-1 → DRAIN.
  - DRAIN: wait until in-flight = 0, the FIFO is empty, and the last handshake has occurred → IDLE, with `done` pulsing in the first IDLE cycle.
- Issue rule: in READ, issue iff fifo_count + inflight < FIFO_DEPTH, where FIFO_DEPTH = RD_LAT+2. `output_index` equals the issue counter in every cycle.
- Issue pipeline: an RD_LAT-deep shift register carries {valid, index}. When it emerges, `ps_data` is pushed into the FIFO with its index and last flag. Push never happens while the FIFO is full; the credit rule guarantees this.
- Stream: the FIFO head drives m_*. A pop occurs on m_valid && m_ready. `m_data`, `m_index` and `m_last` stay stable while m_valid && !m_ready.
- Bins are emitted strictly in order 0..NUM_BINS-1, exactly once each.
- `start` during READ or DRAIN is ignored, with no effect on the counter or the FIFO. `start` in the same cycle as `done` starts a new frame.
- The issue counter stops at NUM_BINS-1 and does not wrap. It returns to 0 only on `start` or `rst`.
- Reset values: state IDLE, output_index 0, busy 0, done 0, m_valid 0, m_data 0, m_index 0, m_last 0. FIFO and issue pipeline are emptied.
- `rst` mid-frame aborts the frame: in-flight reads are discarded, the FIFO is flushed, and `done` is not pulsed.

## Timing
- `start` high in cycle t → READ in t+1, index 0 issued in t+1.
- First m_valid occurs in cycle t+2+RD_LAT (t+3 at the default).
- With m_ready held at 1, throughput is one bin per cycle. The last beat (m_last) lands in t+1+RD_LAT+NUM_BINS, and `done` pulses in t+2+RD_LAT+NUM_BINS (t+2051 at the defaults).
- busy is high t+1 through the last-handshake cycle. busy is low when `done` is high.
- A single stall cycle on m_ready costs at most one cycle of issue once the FIFO fills. Issue resumes the cycle after the credit frees.

## Structure
- Shared package `pitch_shift_pkg` holds:
  - NUM_BINS, IDX_W and DATA_W defaults, shared with the bin buffer and the FFT stages.
  - The reader state enum {IDLE, READ, DRAIN}.
  - A `bin_beat_t` struct {data, index, last}.
- One sub-module, `sync_fifo`, parameterised by width and depth. It provides synchronous push and pop, count output and active-high synchronous flush. Instantiate it once, at depth FIFO_DEPTH and width of `bin_beat_t`.

## Test plan
- Free run: model the buffer as ps_data = {index, ~index} with RD_LAT=1; `start` with m_ready=1 → 2048 beats, m_index 0..2047 contiguous, data matches, m_last only on beat 2047, `done` exactly at t+2051.
- Random backpressure: m_ready 50% random → same 2048-beat sequence with no loss or duplication, held outputs stable during stalls, FIFO never overflows (assertion).
- Latency sweep: RD_LAT = 1, 2 and 4 → first m_valid at t+2+RD_LAT, full-rate throughput with m_ready=1.
- Start handling: `start` re-pulsed mid-frame → ignored, index sequence unchanged; `start` coincident with `done` → second frame begins and is correct.
- Reset mid-frame: assert `rst` at beat 1000 → next cycle all outputs are at reset values, no `done`; a fresh `start` produces a full 0..2047 frame.
- Long stall: m_ready=0 for 50 cycles after `start` → issue halts with FIFO_DEPTH entries held, then resumes in order.
